// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD subtractor: FSM encoding,
// the largest legal BCD digit and the 9's-complement helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Start/done request bus for the serial BCD subtractor; master drives the
// operands and start, slave returns the result, flags and handshake.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic [4*DIGITS-1:0]   diff;
    logic                  neg;
    logic                  err;
    logic                  busy;
    logic                  done;

    modport master (
        output start, a, b,
        input  diff, neg, err, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, neg, err, busy, done
    );
endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder: x + y + cin, corrected by +6 when
// the binary sum leaves the decimal range.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = raw[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |A-B| for packed BCD operands, one digit per clock, with a
// 10's-complement fix-up pass when the result is negative.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_serial_subtractor_if.slave bus
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             carry, carry_nx;
    logic             tail, tail_nx;
    logic [W-1:0]     diff_q, diff_nx;
    logic             neg_q, neg_nx;
    logic             err_q, err_nx;
    logic [W-1:0]     a_q, b_q;
    logic             load;
    logic             ops_bad;

    logic [3:0] a_dig, b_dig, d_dig;
    logic [3:0] add_x, add_y, add_s;
    logic       add_c;

    assign load  = (state == IDLE) && bus.start;
    assign a_dig = a_q[{idx, 2'b00} +: 4];
    assign b_dig = b_q[{idx, 2'b00} +: 4];
    assign d_dig = diff_q[{idx, 2'b00} +: 4];

    // Operand registers only matter while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
    end

    always_comb begin
        ops_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_q[4*i +: 4] > BCD_MAX || b_q[4*i +: 4] > BCD_MAX)
                ops_bad = 1'b1;
        end
    end

    // One adder shared by both passes: A + 9's(B) in SUB, 9's(diff) + 0 in FIX.
    always_comb begin
        if (state == FIX) begin
            add_x = nines_comp(d_dig);
            add_y = 4'd0;
        end else begin
            add_x = a_dig;
            add_y = nines_comp(b_dig);
        end
    end

    bcd_digit_adder u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry),
        .sum  (add_s),
        .cout (add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            tail   <= 1'b0;
            diff_q <= '0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            carry  <= carry_nx;
            tail   <= tail_nx;
            diff_q <= diff_nx;
            neg_q  <= neg_nx;
            err_q  <= err_nx;
        end
    end

    // tail marks the extra SUB cycle that inspects the registered final carry.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        carry_nx = carry;
        tail_nx  = tail;
        diff_nx  = diff_q;
        neg_nx   = neg_q;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    err_nx   = 1'b0;
                    neg_nx   = 1'b0;
                    idx_nx   = '0;
                    carry_nx = 1'b1;
                    tail_nx  = 1'b0;
                    state_nx = SUB;
                end
            end
            SUB: begin
                if (tail) begin
                    tail_nx = 1'b0;
                    if (carry) begin
                        neg_nx   = 1'b0;
                        state_nx = DONE;
                    end else begin
                        neg_nx   = 1'b1;
                        idx_nx   = '0;
                        carry_nx = 1'b1;
                        state_nx = FIX;
                    end
                end else if (ops_bad) begin
                    diff_nx  = '0;
                    neg_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    diff_nx[{idx, 2'b00} +: 4] = add_s;
                    carry_nx = add_c;
                    if (idx == IDX_LAST) begin
                        idx_nx  = '0;
                        tail_nx = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            FIX: begin
                diff_nx[{idx, 2'b00} +: 4] = add_s;
                carry_nx = add_c;
                if (idx == IDX_LAST) begin
                    idx_nx   = '0;
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.diff = diff_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized and directed bench for bcd_serial_subtractor at DIGITS=2 and DIGITS=4,
// checked against an integer-arithmetic reference model.
module tb_bcd_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_serial_subtractor_if #(.DIGITS(2)) bus2 ();
    bcd_serial_subtractor_if #(.DIGITS(4)) bus4 ();

    bcd_serial_subtractor #(.DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    bcd_serial_subtractor #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic samp(input int d, output logic [15:0] diff, output logic neg,
                        output logic err, output logic busy, output logic done);
        if (d == 2) begin
            diff = {8'h00, bus2.diff};
            neg = bus2.neg; err = bus2.err; busy = bus2.busy; done = bus2.done;
        end else begin
            diff = bus4.diff;
            neg = bus4.neg; err = bus4.err; busy = bus4.busy; done = bus4.done;
        end
    endtask

    // Reference: decode to integers, subtract, re-encode the magnitude.
    task automatic ref_model(input int d, input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] diff, output logic neg,
                             output logic err, output int lat);
        int av, bv, m;
        logic [3:0] na, nb;
        av = 0; bv = 0; err = 1'b0; diff = '0; neg = 1'b0;
        for (int i = d - 1; i >= 0; i--) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            if (na > 9 || nb > 9) err = 1'b1;
            av = av * 10 + int'(na);
            bv = bv * 10 + int'(nb);
        end
        if (err) begin
            lat = 1;
        end else begin
            neg = (av < bv);
            m = neg ? bv - av : av - bv;
            lat = neg ? 2 * d + 1 : d + 1;
            for (int i = 0; i < d; i++) begin
                diff[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (d == 2) begin
            bus2.a = a[7:0]; bus2.b = b[7:0]; bus2.start = s;
        end else begin
            bus4.a = a; bus4.b = b; bus4.start = s;
        end
    endtask

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [15:0] e_diff, g_diff;
        logic e_neg, e_err, g_neg, g_err, g_busy, g_done;
        logic digits_ok, busy_ok;
        int e_lat, n;
        ref_model(d, a, b, e_diff, e_neg, e_err, e_lat);
        drive(d, 1'b1, a, b);
        @(posedge clk); #1;
        drive(d, 1'b0, a, b);
        n = 0; digits_ok = 1'b1; busy_ok = 1'b1;
        forever begin
            samp(d, g_diff, g_neg, g_err, g_busy, g_done);
            for (int i = 0; i < d; i++)
                if (g_diff[4*i +: 4] > 4'd9) digits_ok = 1'b0;
            if (!g_busy) busy_ok = 1'b0;
            if (g_done || n >= 40) break;
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(e_lat));
        check({tag, ".diff"}, {16'h0, g_diff}, {16'h0, e_diff});
        check({tag, ".neg"}, {31'h0, g_neg}, {31'h0, e_neg});
        check({tag, ".err"}, {31'h0, g_err}, {31'h0, e_err});
        check({tag, ".digits"}, {31'h0, digits_ok}, 32'h1);
        check({tag, ".busy"}, {31'h0, busy_ok}, 32'h1);
        @(posedge clk); #1;
        samp(d, g_diff, g_neg, g_err, g_busy, g_done);
        check({tag, ".idle"}, {30'h0, g_busy, g_done}, 32'h0);
        check({tag, ".hold"}, {15'h0, g_diff, g_neg}, {15'h0, e_diff, e_neg});
    endtask

    logic [15:0] r_a, r_b, t_diff;
    logic t_neg, t_err, t_busy, t_done;
    int dones;
    logic seen;

    initial begin
        rst_n = 1'b0;
        drive(2, 1'b0, 16'h0, 16'h0);
        drive(4, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        samp(2, t_diff, t_neg, t_err, t_busy, t_done);
        check("reset.outputs", {11'h0, t_diff, t_neg, t_err, t_busy, t_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2, 16'h45, 16'h12, "d2_45_12");
        run_op(2, 16'h12, 16'h45, "d2_12_45");
        run_op(2, 16'h50, 16'h50, "d2_50_50");
        run_op(2, 16'h99, 16'h00, "d2_99_00");
        run_op(2, 16'h00, 16'h99, "d2_00_99");
        run_op(2, 16'h1A, 16'h03, "d2_err");
        run_op(2, 16'h37, 16'h08, "d2_clear_err");

        // start held through a whole operation and its DONE cycle
        drive(2, 1'b1, 16'h12, 16'h45);
        dones = 0; seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus2.done) begin
                dones++; seen = 1'b1;
                t_diff = {8'h0, bus2.diff}; t_neg = bus2.neg;
            end else if (seen) begin
                bus2.start = 1'b0;
            end
        end
        check("held_start.dones", 32'(dones), 32'd1);
        check("held_start.result", {15'h0, t_diff, t_neg}, {15'h0, 16'h0033, 1'b1});
        check("held_start.idle", {31'h0, bus2.busy}, 32'h0);

        // asynchronous reset in the middle of SUB
        drive(2, 1'b1, 16'h45, 16'h12);
        @(posedge clk); #1;
        bus2.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        samp(2, t_diff, t_neg, t_err, t_busy, t_done);
        check("abort.outputs", {11'h0, t_diff, t_neg, t_err, t_busy, t_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus2.done) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);
        run_op(2, 16'h45, 16'h12, "d2_after_abort");

        run_op(4, 16'h0000, 16'h9999, "d4_0000_9999");
        run_op(4, 16'h9999, 16'h0000, "d4_9999_0000");
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 4; i++) begin
                r_a[4*i +: 4] = 4'($urandom_range(0, 9));
                r_b[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if (k == 5) r_b = r_a;
            if (k == 9) r_a[11:8] = 4'($urandom_range(10, 15));
            run_op(4, r_a, r_b, "d4_random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
